// File: rtl/seq_chk_pkg.sv
// Shared types and code tables for the seq_chk sequence checker.
// Sequence order by index: 0,3,4,2,5,7,6,1 (repeating).
package seq_chk_pkg;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StSync   = 2'd1,
    StLocked = 2'd2,
    StSlip   = 2'd3
  } seq_state_e;

  // Packed MSB-first, so element [0] holds the code for index 0.
  localparam logic [7:0][2:0] CodeTable = {3'd1, 3'd6, 3'd7, 3'd5, 3'd2, 3'd4, 3'd3, 3'd0};

  function automatic logic [2:0] idx_to_code(logic [2:0] idx);
    return CodeTable[idx];
  endfunction

  function automatic logic [2:0] code_to_idx(logic [2:0] code);
    logic [2:0] idx;
    case (code)
      3'd0:    idx = 3'd0;
      3'd1:    idx = 3'd7;
      3'd2:    idx = 3'd3;
      3'd3:    idx = 3'd1;
      3'd4:    idx = 3'd2;
      3'd5:    idx = 3'd4;
      3'd6:    idx = 3'd6;
      default: idx = 3'd5;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seq_code_map.sv
// Combinational code<->index translation for the checker sequence.
module seq_code_map
  import seq_chk_pkg::*;
(
  input  logic [2:0] code,
  input  logic [2:0] idx,
  output logic [2:0] code_idx,
  output logic [2:0] idx_code
);

  assign code_idx = code_to_idx(code);
  assign idx_code = idx_to_code(idx);

endmodule

// File: rtl/seq_chk.sv
// Sequence checker: acquires lock on the code stream, flywheels, counts misses.
// Optional period counter output enabled by defining SEQ_CHK_PERIOD_CNT_EN.
module seq_chk
  import seq_chk_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 2,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       in_code,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       exp_code
`ifdef SEQ_CHK_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  localparam logic [3:0] LockCntW = 4'(LOCK_CNT);
  localparam logic [3:0] LossCntW = 4'(LOSS_CNT);

  seq_state_e       state_q, state_d;
  logic [2:0]       exp_idx_q, exp_idx_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic [3:0]       bad_cnt_q, bad_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic             locked_q, locked_d;
  logic [2:0]       exp_code_q, exp_code_d;
  logic [2:0]       in_idx;
  logic             good;
  logic             err_hit;

  seq_code_map u_map (
    .code     (in_code),
    .idx      (exp_idx_d),
    .code_idx (in_idx),
    .idx_code (exp_code_d)
  );

  assign good = (in_idx == exp_idx_q);

  always_comb begin
    state_d    = state_q;
    exp_idx_d  = exp_idx_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    err_hit    = 1'b0;
    if (in_valid) begin
      case (state_q)
        StHunt: begin
          state_d    = StSync;
          good_cnt_d = 4'd0;
          exp_idx_d  = in_idx + 3'd1;
        end
        StSync: begin
          // Re-anchor on every sample; only a run of matches earns lock.
          exp_idx_d = in_idx + 3'd1;
          if (good) begin
            if (good_cnt_q + 4'd1 == LockCntW) begin
              state_d    = StLocked;
              good_cnt_d = 4'd0;
            end else begin
              good_cnt_d = good_cnt_q + 4'd1;
            end
          end else begin
            good_cnt_d = 4'd0;
          end
        end
        StLocked: begin
          exp_idx_d = exp_idx_q + 3'd1;
          if (!good) begin
            err_hit = 1'b1;
            if (LossCntW == 4'd1) begin
              state_d   = StHunt;
              bad_cnt_d = 4'd0;
            end else begin
              state_d   = StSlip;
              bad_cnt_d = 4'd1;
            end
          end
        end
        StSlip: begin
          exp_idx_d = exp_idx_q + 3'd1;
          if (good) begin
            state_d   = StLocked;
            bad_cnt_d = 4'd0;
          end else begin
            err_hit = 1'b1;
            if (bad_cnt_q + 4'd1 == LossCntW) begin
              state_d   = StHunt;
              bad_cnt_d = 4'd0;
            end else begin
              bad_cnt_d = bad_cnt_q + 4'd1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_hit && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
    // Clear wins over a coincident error; the pulse still fires.
    if (clr_err) begin
      err_cnt_d = '0;
    end
    err_pulse_d = err_hit;
    locked_d    = (state_d == StLocked) || (state_d == StSlip);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StHunt;
      exp_idx_q   <= 3'd0;
      good_cnt_q  <= 4'd0;
      bad_cnt_q   <= 4'd0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
      exp_code_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      exp_idx_q   <= exp_idx_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
      exp_code_q  <= exp_code_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign exp_code  = exp_code_q;

`ifdef SEQ_CHK_PERIOD_CNT_EN
  logic [15:0] period_cnt_q, period_cnt_d;

  always_comb begin
    period_cnt_d = period_cnt_q;
    if (in_valid && (state_q == StLocked) && good && (in_idx == 3'd0)) begin
      period_cnt_d = period_cnt_q + 16'd1;
    end
    if ((state_d == StHunt) && (state_q != StHunt)) begin
      period_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_cnt_q <= 16'd0;
    end else begin
      period_cnt_q <= period_cnt_d;
    end
  end

  assign period_cnt = period_cnt_q;
`endif

endmodule

// File: doc/seq_chk.md
Name: seq_chk

Overview:
Downstream checker for the 3-bit Gray-like code sequence 0,3,4,2,5,7,6,1 (repeating) produced by the counter FSM stage. It samples the incoming code and acquires lock after enough consecutive correct steps. Once locked, it flywheels the expected code, flags and counts deviations, and drops lock after repeated misses. Lock and error status go to the status/debug logic.

Parameters:
- LOCK_CNT, 4: consecutive good transitions in SYNC needed to enter LOCKED (range 1..15).
- LOSS_CNT, 2: consecutive bad samples while locked that force return to HUNT (range 1..15).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  in_code is sampled only when high
- in_code  in  3  code from the upstream counter FSM
- clr_err  in  1  synchronous clear of err_cnt
- locked  out  1  high in LOCKED or SLIP
- err_pulse  out  1  one-cycle pulse per counted error
- err_cnt  out  ERR_W  saturating error count
- exp_code  out  3  code expected on the next valid sample

Behaviour:
- Reset is asynchronous, active-low (rst=0), on clock clk. Reset values: state=HUNT, exp_idx=0, good_cnt=0, bad_cnt=0, locked=0, err_pulse=0, err_cnt=0, exp_code=0.
- Index map: idx 0..7 maps to code 0,3,4,2,5,7,6,1. Inverse: code0→0, code1→7, code2→3, code3→1, code4→2, code5→4, code6→6, code7→5.
- A sample is "good" when idx(in_code) == exp_idx. All outputs are registered and update on the edge that takes the sample (visible the next cycle).
- When in_valid=0: all state holds, err_pulse=0.
- HUNT: any valid sample → SYNC; good_cnt=0; exp_idx=idx(in_code)+1 mod 8.
- SYNC:
  - good → good_cnt+1. If it reaches LOCK_CNT → LOCKED and good_cnt=0.
  - bad → good_cnt=0, stay in SYNC.
  - In both cases exp_idx=idx(in_code)+1 (re-anchor). No errors are counted in HUNT or SYNC.
- LOCKED:
  - exp_idx=exp_idx+1 mod 8 on every valid sample (flywheel), regardless of match.
  - bad → err_pulse=1, err_cnt+1, bad_cnt=1. Go to HUNT if LOSS_CNT==1, else SLIP.
- SLIP:
  - Flywheel continues.
  - good → LOCKED, bad_cnt=0.
  - bad → err_pulse, err_cnt+1, bad_cnt+1. On reaching LOSS_CNT → HUNT, bad_cnt=0.
- locked is registered and equals (next state ∈ {LOCKED, SLIP}). It does not drop in SLIP.
- exp_code = code(exp_idx), registered.
- err_cnt saturates at 2^ERR_W−1; the pulse still fires when saturated.
- clr_err together with an error on the same edge → err_cnt=0 (clear wins); err_pulse still 1.
- Reset mid-operation: all outputs return immediately to reset values. Re-acquisition starts from HUNT.

Optional Feature:
- SEQ_CHK_PERIOD_CNT_EN defined:
  - Adds output period_cnt [15:0], reset 0.
  - Increments, wrapping, on each good sample with idx 0 while in LOCKED.
  - Clears on entry to HUNT.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package seq_chk_pkg holds:
  - state encoding HUNT=2'd0, SYNC=2'd1, LOCKED=2'd2, SLIP=2'd3;
  - the 8-entry code table;
  - code_to_idx / idx_to_code functions.
- One combinational sub-module, seq_code_map (code↔idx), is natural. The FSM and counters stay in seq_chk.

Test Plan:
- Reset, then valid clean stream 0,3,4,2,5,7,6,1… → locked=1 after the 5th sample (LOCK_CNT=4); err_cnt=0; exp_code tracks the next code.
- Locked, expecting 5, send 2, then resume with 7 → one err_pulse, err_cnt=1, SLIP then LOCKED; locked stays 1.
- Locked, two consecutive wrong codes → err_cnt=2; locked falls after the 2nd; state HUNT; clean stream relocks after 5 samples.
- Same clean stream with in_valid=0 cycles interleaved → identical lock timing in valid samples; no err_pulse.
- ERR_W=2 with repeated bad/good pairs while locked → err_cnt sticks at 3. clr_err on an error edge → err_cnt=0 with err_pulse=1.
- rst low while LOCKED with err_cnt=5 → locked=0 and err_cnt=0 immediately. With SEQ_CHK_PERIOD_CNT_EN, 3 full clean periods after lock → period_cnt=3.
